// File: rtl/simd_ld_sequencer.sv
// SIMD load sequencer: for one SIMD operation, walks LANES element lanes and drives
// the S/T/D address-register load strobes, the shared address bus, the memory
// read/write requests and the ALU enable. All outputs are registered.
module simd_ld_sequencer #(
    parameter int LANES  = 4,
    parameter int STRIDE = 4,
    parameter int CNT_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      s_base,
    input  logic [31:0]      t_base,
    input  logic [31:0]      d_base,
    input  logic [4:0]       fs_in,
    input  logic             mem_ack,
    output logic             busy,
    output logic             done,
    output logic             s_ld,
    output logic             t_ld,
    output logic             d_ld,
    output logic [31:0]      addrs,
    output logic [4:0]       fs,
    output logic [CNT_W-1:0] lane,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             alu_en
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LD_S = 3'd1,
        LD_T = 3'd2,
        RD   = 3'd3,
        EXEC = 3'd4,
        LD_D = 3'd5,
        WR   = 3'd6,
        DONE = 3'd7
    } state_t;

    state_t           r_state;
    logic [31:0]      r_s_base;
    logic [31:0]      r_t_base;
    logic [31:0]      r_d_base;
    logic [31:0]      r_off;
    logic [4:0]       r_fs;
    logic [CNT_W-1:0] r_lane;
    logic             r_busy;
    logic             r_done;
    logic             r_s_ld;
    logic             r_t_ld;
    logic             r_d_ld;
    logic [31:0]      r_addrs;
    logic             r_mem_rd;
    logic             r_mem_wr;
    logic             r_alu_en;

    logic             w_last_lane;
    logic [31:0]      w_next_off;

    assign w_last_lane = (r_lane == CNT_W'(LANES - 1));
    // Offset of the following lane; addresses wrap modulo 2^32 by construction.
    assign w_next_off  = r_off + 32'(STRIDE);

    // Sequencer FSM: outputs are computed for the state being entered so they
    // appear registered in the same cycle as that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_s_base <= '0;
            r_t_base <= '0;
            r_d_base <= '0;
            r_off    <= '0;
            r_fs     <= '0;
            r_lane   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_s_ld   <= 1'b0;
            r_t_ld   <= 1'b0;
            r_d_ld   <= 1'b0;
            r_addrs  <= '0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_alu_en <= 1'b0;
        end else begin
            // Single-cycle outputs default low; the bus is 0 whenever no strobe is up.
            r_s_ld   <= 1'b0;
            r_t_ld   <= 1'b0;
            r_d_ld   <= 1'b0;
            r_addrs  <= '0;
            r_alu_en <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_s_base <= s_base;
                        r_t_base <= t_base;
                        r_d_base <= d_base;
                        r_fs     <= fs_in;
                        r_lane   <= '0;
                        r_off    <= '0;
                        r_busy   <= 1'b1;
                        r_s_ld   <= 1'b1;
                        r_addrs  <= s_base;
                        r_state  <= LD_S;
                    end
                end
                LD_S: begin
                    r_t_ld  <= 1'b1;
                    r_addrs <= r_t_base + r_off;
                    r_state <= LD_T;
                end
                LD_T: begin
                    r_mem_rd <= 1'b1;
                    r_state  <= RD;
                end
                RD: begin
                    if (mem_ack) begin
                        r_mem_rd <= 1'b0;
                        r_alu_en <= 1'b1;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    r_d_ld  <= 1'b1;
                    r_addrs <= r_d_base + r_off;
                    r_state <= LD_D;
                end
                LD_D: begin
                    r_mem_wr <= 1'b1;
                    r_state  <= WR;
                end
                WR: begin
                    if (mem_ack) begin
                        r_mem_wr <= 1'b0;
                        if (w_last_lane) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_lane  <= r_lane + CNT_W'(1);
                            r_off   <= w_next_off;
                            r_s_ld  <= 1'b1;
                            r_addrs <= r_s_base + w_next_off;
                            r_state <= LD_S;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy   <= 1'b0;
                    r_mem_rd <= 1'b0;
                    r_mem_wr <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign s_ld   = r_s_ld;
    assign t_ld   = r_t_ld;
    assign d_ld   = r_d_ld;
    assign addrs  = r_addrs;
    assign fs     = r_fs;
    assign lane   = r_lane;
    assign mem_rd = r_mem_rd;
    assign mem_wr = r_mem_wr;
    assign alu_en = r_alu_en;

endmodule

// File: tb/tb_simd_ld_sequencer.sv
// Testbench for simd_ld_sequencer: scoreboard of expected strobe/address/lane
// events plus a small memory responder with configurable wait states.
module tb_simd_ld_sequencer;

    localparam int LANES  = 4;
    localparam int STRIDE = 4;
    localparam int CNT_W  = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      s_base = '0;
    logic [31:0]      t_base = '0;
    logic [31:0]      d_base = '0;
    logic [4:0]       fs_in = '0;
    logic             mem_ack = 1'b0;
    logic             busy, done, s_ld, t_ld, d_ld, mem_rd, mem_wr, alu_en;
    logic [31:0]      addrs;
    logic [4:0]       fs;
    logic [CNT_W-1:0] lane;

    simd_ld_sequencer #(.LANES(LANES), .STRIDE(STRIDE), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_base(s_base), .t_base(t_base), .d_base(d_base),
        .fs_in(fs_in), .mem_ack(mem_ack),
        .busy(busy), .done(done), .s_ld(s_ld), .t_ld(t_ld), .d_ld(d_ld),
        .addrs(addrs), .fs(fs), .lane(lane),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_en(alu_en)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    // Scoreboard entry: {lane, kind(1=S,2=T,3=D), address}
    logic [36:0] exp_q[$];
    bit          mon_on = 1'b0;
    bit          ack_tie = 1'b0;
    int          wait_n = 3;
    int          ack_cnt = 0;
    int          rd_len = 0;
    int          wr_len = 0;
    int          exp_hold = 1;
    int          n_done = 0;
    int          n_alu = 0;
    logic [4:0]  exp_fs = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] all_outs();
        return {busy, done, s_ld, t_ld, d_ld, addrs, fs, lane, mem_rd, mem_wr, alu_en};
    endfunction

    // Output monitor and memory responder, sampled away from the active edge.
    always @(negedge clk) begin
        if (mon_on) begin
            logic [1:0]  kind;
            logic [36:0] e;
            if (s_ld | t_ld | d_ld) begin
                kind = s_ld ? 2'd1 : (t_ld ? 2'd2 : 2'd3);
                chk("strobe_onehot", 64'($countones({s_ld, t_ld, d_ld})), 64'(1));
                if (exp_q.size() == 0) begin
                    chk("strobe_extra", 64'({lane, kind, addrs}), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe", 64'({lane, kind, addrs}), 64'(e));
                end
            end else begin
                chk("addrs_nostrobe", 64'(addrs), 64'(0));
            end
            if (busy) chk("fs", 64'(fs), 64'(exp_fs));
            if (done) n_done++;
            if (alu_en) n_alu++;
            if (mem_rd) rd_len++;
            else if (rd_len != 0) begin
                chk("rd_hold", 64'(rd_len), 64'(exp_hold));
                rd_len = 0;
            end
            if (mem_wr) wr_len++;
            else if (wr_len != 0) begin
                chk("wr_hold", 64'(wr_len), 64'(exp_hold));
                wr_len = 0;
            end
        end
        if (ack_tie) begin
            mem_ack = 1'b1;
        end else if (mem_rd === 1'b1 || mem_wr === 1'b1) begin
            ack_cnt++;
            mem_ack = (ack_cnt >= wait_n);
            if (ack_cnt >= wait_n) ack_cnt = 0;
        end else begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end
    end

    task automatic push_op(input logic [31:0] sb, input logic [31:0] tb, input logic [31:0] db);
        for (int i = 0; i < LANES; i++) begin
            exp_q.push_back({CNT_W'(i), 2'd1, sb + 32'(i * STRIDE)});
            exp_q.push_back({CNT_W'(i), 2'd2, tb + 32'(i * STRIDE)});
            exp_q.push_back({CNT_W'(i), 2'd3, db + 32'(i * STRIDE)});
        end
    endtask

    task automatic run_op(input logic [31:0] sb, input logic [31:0] tb, input logic [31:0] db,
                          input logic [4:0] f, input int wt, input int exp_lat, input int poke_at);
        int  n;
        bit  got;
        @(negedge clk);
        s_base   = sb;
        t_base   = tb;
        d_base   = db;
        fs_in    = f;
        start    = 1'b1;
        exp_fs   = f;
        wait_n   = wt;
        ack_tie  = (wt == 0);
        exp_hold = (wt == 0) ? 1 : wt;
        n_done   = 0;
        n_alu    = 0;
        push_op(sb, tb, db);
        @(posedge clk);
        #1;
        start  = 1'b0;
        s_base = 32'hDEAD_0000;
        t_base = 32'hBEEF_0000;
        d_base = 32'hCAFE_0000;
        fs_in  = 5'h1F;
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (n == poke_at) begin
                start  = 1'b1;
                s_base = 32'h900;
            end else begin
                start = 1'b0;
            end
            if (done) got = 1'b1;
        end
        chk("done_latency", 64'(n), 64'(exp_lat));
        @(negedge clk);
        chk("done_count", 64'(n_done), 64'(1));
        chk("busy_after_done", 64'(busy), 64'(0));
        chk("alu_count", 64'(n_alu), 64'(LANES));
        chk("queue_left", 64'(exp_q.size()), 64'(0));
        chk("fs_hold_idle", 64'(fs), 64'(f));
        chk("lane_hold_idle", 64'(lane), 64'(LANES - 1));
        exp_q.delete();
    endtask

    task automatic reset_mid_op();
        int n;
        @(negedge clk);
        s_base  = 32'h4000;
        t_base  = 32'h5000;
        d_base  = 32'h6000;
        fs_in   = 5'h07;
        start   = 1'b1;
        exp_fs  = 5'h07;
        ack_tie = 1'b1;
        exp_hold = 1;
        n_done  = 0;
        push_op(32'h4000, 32'h5000, 32'h6000);
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!(mem_wr === 1'b1 && lane == CNT_W'(1)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wr_lane1", 64'({mem_wr, lane}), 64'({1'b1, CNT_W'(1)}));
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_outs", 64'(all_outs()), 64'(0));
        exp_q.delete();
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_mid_nodone", 64'(n_done), 64'(0));
        chk("reset_mid_idle", 64'({busy, mem_rd, mem_wr}), 64'(0));
    endtask

    initial begin
        // Reset held two cycles, then quiet idle period.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 64'(all_outs()), 64'(0));
        reset  = 1'b0;
        mon_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_quiet", 64'({s_ld, t_ld, d_ld, mem_rd, mem_wr, alu_en, busy, done}), 64'(0));
        end

        // Zero-wait memory.
        run_op(32'h100, 32'h200, 32'h300, 5'h0A, 0, 25, 0);
        // Three-cycle memory latency on every request.
        run_op(32'h1000, 32'h2000, 32'h3000, 5'h15, 3, 41, 0);
        // Address wrap past 2^32.
        run_op(32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h40, 5'h03, 0, 25, 0);
        // Start pulsed during lane 2 must be ignored.
        run_op(32'h700, 32'h710, 32'h720, 5'h11, 0, 25, 14);
        repeat (3) @(negedge clk);
        chk("no_restart", 64'(busy), 64'(0));
        // Reset during write-back of lane 1, then a full operation from lane 0.
        reset_mid_op();
        run_op(32'h100, 32'h200, 32'h300, 5'h0A, 0, 25, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
